fft_addr_gen: RTL and testbench

Control and address-generation stage for the 32-point radix-2 FFT datapath. It sits directly upstream of the butterfly unit and the FFT data memory. It sequences all butterfly stages, and drives:
- the read addresses and twiddle address,
- the bank ping-pong select,
- write addresses, delayed to match the BFU/memory pipeline,
- the write enables and the completion pulse.

It assumes bit-reversed input is already loaded into bank 0.

---
 rtl/fft_addr_gen_if.sv | 33 +++
 rtl/fft_addr_gen.sv | 135 +++++++++++++
 tb/tb_fft_addr_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fft_addr_gen_if.sv
// Bus between the FFT controller and the butterfly/memory datapath it sequences.
// The controller takes the master side; the datapath observes through the slave side.
interface fft_addr_gen_if #(
    parameter int N_LOG2 = 5
);
    logic              start;
    logic              busy;
    logic [N_LOG2-1:0] MemA_address;
    logic [N_LOG2-1:0] MemB_address;
    logic [N_LOG2-2:0] twiddle_address;
    logic              mem_write;
    logic              MemBankReadSelect;
    logic [N_LOG2-1:0] MemA_address_9delay;
    logic [N_LOG2-1:0] MemB_address_9delay;
    logic              memwrite_9delay;
    logic              Bank0WriteEN;
    logic              Bank1WriteEN;
    logic              FFT_done;

    modport master (
        input  start,
        output busy, MemA_address, MemB_address, twiddle_address, mem_write,
               MemBankReadSelect, MemA_address_9delay, MemB_address_9delay,
               memwrite_9delay, Bank0WriteEN, Bank1WriteEN, FFT_done
    );

    modport slave (
        output start,
        input  busy, MemA_address, MemB_address, twiddle_address, mem_write,
               MemBankReadSelect, MemA_address_9delay, MemB_address_9delay,
               memwrite_9delay, Bank0WriteEN, Bank1WriteEN, FFT_done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT with ping-pong banks.
//
// state | meaning
// IDLE  | waiting for start; no butterflies issued
// ISSUE | one butterfly read issued per cycle for the current stage
// DRAIN | PIPE_DELAY idle cycles so the stage's last write lands before the next stage reads
// DONE  | one-cycle completion pulse
module fft_addr_gen #(
    parameter int N_LOG2     = 5,
    parameter int PIPE_DELAY = 9
) (
    input  logic          clock,
    input  logic          reset,
    fft_addr_gen_if.master bus
);

    localparam int AW = N_LOG2;
    localparam int TW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int DW = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;

    localparam logic [TW-1:0] J_MAX      = '1;
    localparam logic [SW-1:0] S_LAST     = SW'(N_LOG2 - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DELAY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          we;
        logic          bank;
    } wb_t;

    state_t        state, state_nxt;
    logic [SW-1:0] stage;
    logic [TW-1:0] bfly;
    logic [DW-1:0] drain_cnt;
    logic          issue;

    logic [AW-1:0] j_ext, half, mask, pos, addr_a, addr_b;
    logic [TW-1:0] tw;

    wb_t dly [PIPE_DELAY];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ISSUE;
            ISSUE:   if (bfly == J_MAX) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = (stage == S_LAST) ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // drain_cnt is a down-counter; terminal count 0 ends the drain window
    always_ff @(posedge clock) begin
        if (reset) begin
            stage     <= '0;
            bfly      <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        stage <= '0;
                        bfly  <= '0;
                    end
                end
                ISSUE: begin
                    bfly <= bfly + TW'(1);
                    if (bfly == J_MAX) drain_cnt <= DRAIN_LOAD;
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (stage != S_LAST) begin
                            stage <= stage + SW'(1);
                            bfly  <= '0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // grp*2^(s+1) is just j with its low s bits cleared, shifted left once
    always_comb begin
        j_ext  = {1'b0, bfly};
        half   = AW'(1) << stage;
        mask   = half - AW'(1);
        pos    = j_ext & mask;
        addr_a = ((j_ext & ~mask) << 1) | pos;
        addr_b = addr_a | half;
        tw     = pos[TW-1:0] << (TW - int'(stage));
    end

    always_comb begin
        issue                   = (state == ISSUE);
        bus.busy                = issue || (state == DRAIN);
        bus.mem_write           = issue;
        bus.MemA_address        = issue ? addr_a : '0;
        bus.MemB_address        = issue ? addr_b : '0;
        bus.twiddle_address     = issue ? tw : '0;
        bus.MemBankReadSelect   = stage[0];
        bus.FFT_done            = (state == DONE);
        bus.MemA_address_9delay = dly[PIPE_DELAY-1].a;
        bus.MemB_address_9delay = dly[PIPE_DELAY-1].b;
        bus.memwrite_9delay     = dly[PIPE_DELAY-1].we;
        bus.Bank0WriteEN        = dly[PIPE_DELAY-1].we & ~dly[PIPE_DELAY-1].bank;
        bus.Bank1WriteEN        = dly[PIPE_DELAY-1].we &  dly[PIPE_DELAY-1].bank;
    end

    // write bank travels with the butterfly so a stage change cannot retarget it
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) dly[i] <= '0;
        end else begin
            dly[0].a    <= bus.MemA_address;
            dly[0].b    <= bus.MemB_address;
            dly[0].we   <= issue;
            dly[0].bank <= ~stage[0];
            for (int i = 1; i < PIPE_DELAY; i++) dly[i] <= dly[i-1];
        end
    end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: every output compared each cycle against a schedule
// computed from the stage/butterfly address formulas, with randomized start noise and resets.
module tb_fft_addr_gen;

    localparam int NL       = 5;
    localparam int P        = 9;
    localparam int NBF      = 16;
    localparam int ST       = NBF + P;
    localparam int LAST     = NL * ST;
    localparam int DONE_CYC = LAST + 1;

    typedef struct packed {
        logic       busy;
        logic       mw;
        logic       rsel;
        logic [4:0] a;
        logic [4:0] b;
        logic [3:0] tw;
        logic       mw9;
        logic [4:0] a9;
        logic [4:0] b9;
        logic       en0;
        logic       en1;
        logic       done;
    } exp_t;

    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    int sp_cyc [5] = '{1, 2, 27, 56, 106};
    int sp_a   [5] = '{0, 2, 1, 9, 5};
    int sp_b   [5] = '{1, 3, 3, 13, 21};
    int sp_tw  [5] = '{0, 0, 8, 4, 5};
    int sp_rs  [5] = '{0, 0, 1, 0, 0};

    fft_addr_gen_if #(.N_LOG2(NL)) bus ();

    fft_addr_gen #(.N_LOG2(NL), .PIPE_DELAY(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, c, got, want);
        end
    endtask

    task automatic bfly(input int s, input int j, output int a, output int b, output int tw);
        int half, pos, grp;
        half = 1 << s;
        pos  = j % half;
        grp  = j / half;
        a    = grp * 2 * half + pos;
        b    = a + half;
        tw   = (pos * (1 << (NL - 1 - s))) % (1 << (NL - 1));
    endtask

    // c counts cycles from the one in which start is driven high
    task automatic model(input int c, input int rst_at, output exp_t e);
        int s, j, a, b, tw, t;
        e = '0;
        if (rst_at >= 0 && c > rst_at) return;
        if (c >= 1 && c <= LAST) begin
            s      = (c - 1) / ST;
            j      = (c - 1) % ST;
            e.busy = 1'b1;
            e.rsel = (s % 2 == 1);
            if (j < NBF) begin
                bfly(s, j, a, b, tw);
                e.mw = 1'b1;
                e.a  = 5'(a);
                e.b  = 5'(b);
                e.tw = 4'(tw);
            end
        end
        t = c - P;
        if (t >= 1 && t <= LAST && (t - 1) % ST < NBF) begin
            s = (t - 1) / ST;
            j = (t - 1) % ST;
            bfly(s, j, a, b, tw);
            e.mw9 = 1'b1;
            e.a9  = 5'(a);
            e.b9  = 5'(b);
            e.en1 = (s % 2 == 0);
            e.en0 = (s % 2 == 1);
        end
        e.done = (c == DONE_CYC);
    endtask

    task automatic check_cycle(input int c, input exp_t e);
        chk("busy",  c, 32'(bus.busy),                e.busy);
        chk("mw",    c, 32'(bus.mem_write),           e.mw);
        chk("rsel",  c, 32'(bus.MemBankReadSelect),   e.rsel);
        chk("addrA", c, 32'(bus.MemA_address),        32'(e.a));
        chk("addrB", c, 32'(bus.MemB_address),        32'(e.b));
        chk("tw",    c, 32'(bus.twiddle_address),     32'(e.tw));
        chk("mw9",   c, 32'(bus.memwrite_9delay),     e.mw9);
        chk("addrA9",c, 32'(bus.MemA_address_9delay), 32'(e.a9));
        chk("addrB9",c, 32'(bus.MemB_address_9delay), 32'(e.b9));
        chk("wen0",  c, 32'(bus.Bank0WriteEN),        e.en0);
        chk("wen1",  c, 32'(bus.Bank1WriteEN),        e.en1);
        chk("done",  c, 32'(bus.FFT_done),            e.done);
    endtask

    task automatic run_fft(input int rst_at, input int spur, input bit noise, input int gap);
        exp_t e;
        int   n_mw, n_mw9, n_done;
        n_mw = 0; n_mw9 = 0; n_done = 0;
        repeat (gap) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
            @(negedge clock);
            check_cycle(-1, '0);
        end
        for (int c = 0; c <= DONE_CYC + 4; c++) begin
            @(posedge clock); #1;
            if (c == 0)                          bus.start = 1'b1;
            else if (rst_at >= 0 && c >= rst_at) bus.start = 1'b0;
            else if (noise && c <= DONE_CYC)     bus.start = 1'($urandom_range(0, 1));
            else                                 bus.start = (c == spur);
            reset = (c == rst_at);
            @(negedge clock);
            model(c, rst_at, e);
            check_cycle(c, e);
            if (bus.mem_write)       n_mw++;
            if (bus.memwrite_9delay) n_mw9++;
            if (bus.FFT_done)        n_done++;
            if (rst_at < 0 || c <= rst_at) begin
                for (int k = 0; k < 5; k++) begin
                    if (c == sp_cyc[k]) begin
                        chk("spotA",  c, 32'(bus.MemA_address),      sp_a[k]);
                        chk("spotB",  c, 32'(bus.MemB_address),      sp_b[k]);
                        chk("spotTw", c, 32'(bus.twiddle_address),   sp_tw[k]);
                        chk("spotRs", c, 32'(bus.MemBankReadSelect), sp_rs[k]);
                    end
                end
                if (c == 10 || c == 115) begin
                    chk("spotMw9", c, 32'(bus.memwrite_9delay),     1);
                    chk("spotA9",  c, 32'(bus.MemA_address_9delay), (c == 10) ? 0 : 5);
                    chk("spotEn1", c, 32'(bus.Bank1WriteEN),        1);
                end
            end
        end
        reset = 1'b0;
        bus.start = 1'b0;
        if (rst_at < 0) begin
            chk("n_write",  -1, n_mw,   NL * NBF);
            chk("n_write9", -1, n_mw9,  NL * NBF);
            chk("n_done",   -1, n_done, 1);
        end else begin
            chk("n_done_rst", -1, n_done, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (i == 2) reset = 1'b0;
            @(negedge clock);
            check_cycle(-1, '0);
        end
        repeat (20) begin
            @(posedge clock); #1;
            @(negedge clock);
            check_cycle(-1, '0);
        end

        run_fft(-1, 40, 1'b0, 1);
        run_fft(-1, int'($urandom_range(1, DONE_CYC)), 1'b1, int'($urandom_range(0, 6)));
        run_fft(60, -1, 1'b0, 2);
        run_fft(-1, -1, 1'b0, 0);
        run_fft(int'($urandom_range(2, 120)), -1, 1'b1, int'($urandom_range(0, 6)));
        run_fft(-1, -1, 1'b1, int'($urandom_range(0, 6)));
        run_fft(-1, int'($urandom_range(1, DONE_CYC)), 1'b1, int'($urandom_range(0, 6)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
